spectrometer_frame_ctrl: RTL and testbench
==========================================

Name: spectrometer_frame_ctrl

Overview:
Frame sequencer between the GPIO stream pins and the spectrometer datapath. It admits exactly one configured frame of input samples per start command and generates the input last flag on the final sample. It counts the result beats and generates the output last flag on the final beat. It reports done, watchdog timeout and last-flag mismatch to the management side.

Parameters:
IN_W, 8, input sample width
OUT_W, 16, output beat width
CNT_W, 16, frame/beat counter width
TO_W, 20, watchdog counter width

Ports:
clock  input  1  system clock
RSTB  input  1  reset, synchronous, active-high
start  input  1  one-cycle pulse: begin frame (honoured in IDLE only)
abort  input  1  one-cycle pulse: return to IDLE from any state
cfg_in_len  input  CNT_W  input samples per frame
cfg_out_len  input  CNT_W  output beats per frame
cfg_timeout  input  TO_W  idle-cycle limit; 0 disables watchdog
s_in_valid / s_in_ready / s_in_data[IN_W]  in/out/in  upstream sample stream
dp_in_valid / dp_in_ready / dp_in_data[IN_W] / dp_in_last  out/in/out/out  to datapath
dp_out_valid / dp_out_ready / dp_out_data[OUT_W] / dp_out_last  in/out/in/in  from datapath
m_out_valid / m_out_ready / m_out_data[OUT_W] / m_out_last  out/in/out/out  downstream result stream
busy  output  1  high in LOAD or DRAIN
done  output  1  one-cycle pulse on frame completion
err_timeout  output  1  sticky until next start or abort
err_last  output  1  sticky: dp_out_last disagreed with the generated last
err_cfg  output  1  one-cycle pulse: start rejected
in_cnt / out_cnt  output  CNT_W  live beat counters

Behaviour:
- States: IDLE, LOAD, DRAIN, DONE, ERR. Reset puts the block in IDLE.
- Reset values: all outputs 0, counters 0, latched config 0.
- IDLE: s_in_ready=0, dp_in_valid=0, dp_out_ready=0, m_out_valid=0.
- start in IDLE with cfg_in_len=0 or cfg_out_len=0: err_cfg pulses next cycle and the block stays in IDLE.
- start in IDLE with both lengths nonzero: latch all three cfg values, clear counters, clear err_timeout and err_last, go to LOAD.
- LOAD input path, combinational pass-through: dp_in_valid=s_in_valid, s_in_ready=dp_in_ready, dp_in_data=s_in_data. dp_in_last=(in_cnt==len_in-1).
- in_cnt increments on each dp_in handshake. The handshake where dp_in_last=1 sets in_done.
- In LOAD with in_done set: s_in_ready=0 and dp_in_valid=0. No extra samples pass.
- Output path in LOAD and DRAIN, combinational: m_out_valid=dp_out_valid, dp_out_ready=m_out_ready, m_out_data=dp_out_data. m_out_last=(out_cnt==len_out-1).
- out_cnt increments on each m_out handshake. The handshake where m_out_last=1 sets out_done. After out_done, dp_out_ready=0 and m_out_valid=0.
- err_last sets on any m_out handshake where dp_out_last differs from m_out_last.
- LOAD→DRAIN when in_done is set and out_done is not. LOAD→DONE when both are set. DRAIN→DONE when out_done is set. Same-cycle completion of both streams goes straight to DONE.
- DONE: lasts 1 cycle, done=1, then IDLE. in_cnt and out_cnt hold their final values until the next start.
- Watchdog: counter clears on any dp_in or m_out handshake and on state entry. Otherwise it increments while busy.
- When cfg_timeout≠0 and the watchdog reaches cfg_timeout: go to ERR and set err_timeout.
- ERR: s_in_ready=0, dp_in_valid=0, m_out_valid=0. dp_out_ready=1, so datapath output is drained and discarded. The block stays in ERR until abort.
- abort in any state: IDLE next cycle, counters cleared, err flags cleared. abort has priority over start and over every other transition in the same cycle.
- RSTB mid-frame: the block behaves exactly as after power-up reset. Nothing is retained.
- Counter arithmetic is unsigned CNT_W. Lengths up to 2^CNT_W−1 are supported, with no wrap inside a frame.
- Latency: zero cycles on both data paths, which are combinational. Control response to start/abort is one cycle.

Test Plan:
- Nominal frame: cfg_in_len=2048, cfg_out_len=1536, cfg_timeout=0, start; source always valid, sink always ready, model datapath. Required: exactly 2048 dp_in beats, dp_in_last only on beat 2047; 1536 m_out beats, m_out_last only on beat 1535; done pulses once; busy falls the same cycle done rises.
- Backpressure: random dp_in_ready and m_out_ready at 50%. Required: same counts as the nominal frame; data order identical to golden; no beat dropped or duplicated; no sample accepted after in_done.
- Early output: datapath emits all 4 output beats with len_in=8, len_out=4 before the last input sample. Required: the block waits in LOAD with out_done set, goes to DONE after input beat 8, done pulses once.
- Timeout: len_in=16, cfg_timeout=100; stall the source after 5 samples. Required: ERR entered exactly 100 cycles after the last handshake; err_timeout=1; s_in_ready=0; abort returns to IDLE with err_timeout=0.
- Config errors and mismatch: start with cfg_out_len=0 → err_cfg pulse, state stays IDLE. A frame with dp_out_last asserted on beat 2 of 4 → err_last=1 and the frame still completes with done.
- Abort and reset: abort asserted on the same cycle as the final input handshake → IDLE next cycle, no done pulse. RSTB asserted mid-LOAD → all outputs 0 the next cycle.

Source files
------------

// File: rtl/spectrometer_frame_ctrl.sv
// Frame sequencer between the GPIO sample stream and the spectrometer datapath.
// Admits one configured frame per start, generates last flags, and watchdogs stalled frames.
module spectrometer_frame_ctrl #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16,
    parameter int TO_W  = 20
) (
    input  logic             clock,
    input  logic             RSTB,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_in_len,
    input  logic [CNT_W-1:0] cfg_out_len,
    input  logic [TO_W-1:0]  cfg_timeout,
    input  logic             s_in_valid,
    output logic             s_in_ready,
    input  logic [IN_W-1:0]  s_in_data,
    output logic             dp_in_valid,
    input  logic             dp_in_ready,
    output logic [IN_W-1:0]  dp_in_data,
    output logic             dp_in_last,
    input  logic             dp_out_valid,
    output logic             dp_out_ready,
    input  logic [OUT_W-1:0] dp_out_data,
    input  logic             dp_out_last,
    output logic             m_out_valid,
    input  logic             m_out_ready,
    output logic [OUT_W-1:0] m_out_data,
    output logic             m_out_last,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic             err_last,
    output logic             err_cfg,
    output logic [CNT_W-1:0] in_cnt,
    output logic [CNT_W-1:0] out_cnt,
    output logic [2:0]       dbg_state
);

    // Every stream transfers a beat on a cycle where valid and ready are both high;
    // both paths are combinational, so a beat crosses this block in the same cycle.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0]  TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  len_in;
    logic [CNT_W-1:0]  len_out;
    logic [TO_W-1:0]   to_lim;
    logic [TO_W-1:0]   wd_cnt;
    logic [TO_W-1:0]   wd_inc;
    logic              in_done;
    logic              out_done;
    logic              in_open;
    logic              out_open;
    logic              in_hs;
    logic              out_hs;
    logic              in_done_nxt;
    logic              out_done_nxt;
    logic              wd_fire;
    logic              cfg_ok;

    always_ff @(posedge clock) begin
        if (RSTB) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        in_open      = (state == S_LOAD) && !in_done;
        out_open     = ((state == S_LOAD) || (state == S_DRAIN)) && !out_done;
        s_in_ready   = in_open && dp_in_ready;
        dp_in_valid  = in_open && s_in_valid;
        dp_in_data   = in_open ? s_in_data : '0;
        dp_in_last   = in_open && (in_cnt == len_in - CNT_ONE);
        m_out_valid  = out_open && dp_out_valid;
        // In ERR the datapath is drained and its results are thrown away.
        dp_out_ready = (out_open && m_out_ready) || (state == S_ERR);
        m_out_data   = out_open ? dp_out_data : '0;
        m_out_last   = out_open && (out_cnt == len_out - CNT_ONE);
        in_hs        = dp_in_valid && dp_in_ready;
        out_hs       = m_out_valid && m_out_ready;
        in_done_nxt  = in_done || (in_hs && dp_in_last);
        out_done_nxt = out_done || (out_hs && m_out_last);
        busy         = (state == S_LOAD) || (state == S_DRAIN);
        done         = (state == S_DONE);
        cfg_ok       = (cfg_in_len != '0) && (cfg_out_len != '0);
        wd_inc       = wd_cnt + TO_ONE;
        wd_fire      = busy && (to_lim != '0) && !in_hs && !out_hs && (wd_inc == to_lim);

        case (state)
            S_IDLE:  if (start && cfg_ok) state_nxt = S_LOAD;
            S_LOAD: begin
                if (in_done_nxt && out_done_nxt) state_nxt = S_DONE;
                else if (in_done_nxt)            state_nxt = S_DRAIN;
                else if (wd_fire)                state_nxt = S_ERR;
            end
            S_DRAIN: begin
                if (out_done_nxt) state_nxt = S_DONE;
                else if (wd_fire) state_nxt = S_ERR;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
        endcase

        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clock) begin
        if (RSTB) begin
            len_in      <= '0;
            len_out     <= '0;
            to_lim      <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            in_done     <= 1'b0;
            out_done    <= 1'b0;
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
            err_last    <= 1'b0;
            err_cfg     <= 1'b0;
        end else begin
            err_cfg <= 1'b0;
            if (abort) begin
                in_cnt      <= '0;
                out_cnt     <= '0;
                in_done     <= 1'b0;
                out_done    <= 1'b0;
                wd_cnt      <= '0;
                err_timeout <= 1'b0;
                err_last    <= 1'b0;
            end else if ((state == S_IDLE) && start) begin
                if (!cfg_ok) begin
                    err_cfg <= 1'b1;
                end else begin
                    len_in      <= cfg_in_len;
                    len_out     <= cfg_out_len;
                    to_lim      <= cfg_timeout;
                    in_cnt      <= '0;
                    out_cnt     <= '0;
                    in_done     <= 1'b0;
                    out_done    <= 1'b0;
                    wd_cnt      <= '0;
                    err_timeout <= 1'b0;
                    err_last    <= 1'b0;
                end
            end else begin
                if (in_hs)  in_cnt  <= in_cnt + CNT_ONE;
                if (out_hs) out_cnt <= out_cnt + CNT_ONE;
                in_done  <= in_done_nxt;
                out_done <= out_done_nxt;
                // Watchdog measures idle cycles since the last transfer or state change.
                if (in_hs || out_hs || (state_nxt != state)) wd_cnt <= '0;
                else if (busy)                                wd_cnt <= wd_inc;
                if (wd_fire) err_timeout <= 1'b1;
                if (out_hs && (dp_out_last != m_out_last)) err_last <= 1'b1;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_spectrometer_frame_ctrl.sv
// Randomized bench for spectrometer_frame_ctrl: per-frame scoreboards for both streams,
// plus directed config-error, timeout, abort and reset scenarios.
module tb_spectrometer_frame_ctrl;

    localparam int IN_W  = 8;
    localparam int OUT_W = 16;
    localparam int CNT_W = 16;
    localparam int TO_W  = 20;

    logic             clock;
    logic             RSTB;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] cfg_in_len;
    logic [CNT_W-1:0] cfg_out_len;
    logic [TO_W-1:0]  cfg_timeout;
    logic             s_in_valid;
    logic             s_in_ready;
    logic [IN_W-1:0]  s_in_data;
    logic             dp_in_valid;
    logic             dp_in_ready;
    logic [IN_W-1:0]  dp_in_data;
    logic             dp_in_last;
    logic             dp_out_valid;
    logic             dp_out_ready;
    logic [OUT_W-1:0] dp_out_data;
    logic             dp_out_last;
    logic             m_out_valid;
    logic             m_out_ready;
    logic [OUT_W-1:0] m_out_data;
    logic             m_out_last;
    logic             busy;
    logic             done;
    logic             err_timeout;
    logic             err_last;
    logic             err_cfg;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic [2:0]       dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    spectrometer_frame_ctrl #(
        .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .TO_W(TO_W)
    ) dut (
        .clock(clock), .RSTB(RSTB), .start(start), .abort(abort),
        .cfg_in_len(cfg_in_len), .cfg_out_len(cfg_out_len), .cfg_timeout(cfg_timeout),
        .s_in_valid(s_in_valid), .s_in_ready(s_in_ready), .s_in_data(s_in_data),
        .dp_in_valid(dp_in_valid), .dp_in_ready(dp_in_ready), .dp_in_data(dp_in_data),
        .dp_in_last(dp_in_last),
        .dp_out_valid(dp_out_valid), .dp_out_ready(dp_out_ready), .dp_out_data(dp_out_data),
        .dp_out_last(dp_out_last),
        .m_out_valid(m_out_valid), .m_out_ready(m_out_ready), .m_out_data(m_out_data),
        .m_out_last(m_out_last),
        .busy(busy), .done(done), .err_timeout(err_timeout), .err_last(err_last),
        .err_cfg(err_cfg), .in_cnt(in_cnt), .out_cnt(out_cnt), .dbg_state(dbg_state)
    );

    // Clock and global time guard
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #50000000;
        $display("FAIL global_time_limit: got running expected finished");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic idle_inputs();
        start        = 1'b0;
        abort        = 1'b0;
        s_in_valid   = 1'b0;
        s_in_data    = '0;
        dp_in_ready  = 1'b0;
        dp_out_valid = 1'b0;
        dp_out_data  = '0;
        dp_out_last  = 1'b0;
        m_out_ready  = 1'b0;
    endtask

    task automatic drive_all_active();
        s_in_valid   = 1'b1;
        s_in_data    = 8'hA5;
        dp_in_ready  = 1'b1;
        dp_out_valid = 1'b1;
        dp_out_data  = 16'hBEEF;
        dp_out_last  = 1'b1;
        m_out_ready  = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_s_in_ready"},   s_in_ready, 0);
        check_eq({tag, "_dp_in_valid"},  dp_in_valid, 0);
        check_eq({tag, "_dp_in_data"},   dp_in_data, 0);
        check_eq({tag, "_dp_in_last"},   dp_in_last, 0);
        check_eq({tag, "_dp_out_ready"}, dp_out_ready, 0);
        check_eq({tag, "_m_out_valid"},  m_out_valid, 0);
        check_eq({tag, "_m_out_data"},   m_out_data, 0);
        check_eq({tag, "_m_out_last"},   m_out_last, 0);
        check_eq({tag, "_busy"},         busy, 0);
        check_eq({tag, "_done"},         done, 0);
        check_eq({tag, "_err_timeout"},  err_timeout, 0);
        check_eq({tag, "_err_last"},     err_last, 0);
        check_eq({tag, "_err_cfg"},      err_cfg, 0);
        check_eq({tag, "_in_cnt"},       in_cnt, 0);
        check_eq({tag, "_out_cnt"},      out_cnt, 0);
    endtask

    // One frame against the reference model: a source of unlimited random samples,
    // a datapath that offers len_out random beats, and FIFO scoreboards for both paths.
    task automatic run_frame(input int len_in, input int len_out, input int rdy_pct,
                             input int vld_pct, input bit early_out, input int bad_beat,
                             input bit abort_last);
        logic [IN_W-1:0]  in_q[$];
        logic [OUT_W-1:0] exp_q[$];
        logic [IN_W-1:0]  cur_src;
        logic [OUT_W-1:0] cur_dpo;
        int in_n = 0;
        int out_n = 0;
        int dpo_idx = 0;
        int cyc = 0;
        bit fin = 0;
        bit aborting = 0;
        bit complete;
        bit exp_err_last = 0;

        cur_src = IN_W'($urandom);
        cur_dpo = OUT_W'($urandom);
        @(posedge clock); #1;
        cfg_in_len  = CNT_W'(len_in);
        cfg_out_len = CNT_W'(len_out);
        cfg_timeout = '0;
        start       = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;

        while (!fin && cyc < 20000) begin
            s_in_valid   = ($urandom_range(0, 99) < vld_pct);
            s_in_data    = cur_src;
            dp_in_ready  = ($urandom_range(0, 99) < rdy_pct);
            m_out_ready  = ($urandom_range(0, 99) < rdy_pct);
            dp_out_valid = (dpo_idx < len_out) && ($urandom_range(0, 99) < vld_pct);
            dp_out_data  = cur_dpo;
            dp_out_last  = (dpo_idx == len_out - 1) != (dpo_idx == bad_beat);
            if (early_out && in_n == len_in - 1 && dpo_idx < len_out) s_in_valid = 1'b0;
            if (abort_last && in_n == len_in - 1 && dpo_idx == len_out) begin
                s_in_valid  = 1'b1;
                dp_in_ready = 1'b1;
                abort       = 1'b1;
                aborting    = 1;
            end

            @(negedge clock);
            complete = (in_n == len_in) && (out_n == len_out);
            check_eq("busy", busy, !complete);
            check_eq("done", done, complete);
            check_eq("s_in_ready", s_in_ready, (in_n < len_in) && dp_in_ready);
            check_eq("dp_in_valid", dp_in_valid, (in_n < len_in) && s_in_valid);
            check_eq("dp_out_ready", dp_out_ready, (out_n < len_out) && m_out_ready);
            check_eq("m_out_valid", m_out_valid, (out_n < len_out) && dp_out_valid);

            if (s_in_valid && s_in_ready) begin
                in_q.push_back(s_in_data);
                cur_src = IN_W'($urandom);
            end
            if (dp_in_valid && dp_in_ready) begin
                if (in_q.size() > 0) check_eq("dp_in_data", dp_in_data, in_q.pop_front());
                else                 check_eq("dp_in_src_pending", in_q.size(), 1);
                check_eq("dp_in_last", dp_in_last, in_n == len_in - 1);
                check_eq("in_cnt_live", in_cnt, in_n);
                in_n++;
            end
            if (dp_out_valid && dp_out_ready) begin
                exp_q.push_back(dp_out_data);
                if (dpo_idx == bad_beat) exp_err_last = 1;
                dpo_idx++;
                cur_dpo = OUT_W'($urandom);
            end
            if (m_out_valid && m_out_ready) begin
                if (exp_q.size() > 0) check_eq("m_out_data", m_out_data, exp_q.pop_front());
                else                  check_eq("m_out_dp_pending", exp_q.size(), 1);
                check_eq("m_out_last", m_out_last, out_n == len_out - 1);
                check_eq("out_cnt_live", out_cnt, out_n);
                out_n++;
            end
            if (complete) begin
                check_eq("final_in_cnt", in_cnt, len_in);
                check_eq("final_out_cnt", out_cnt, len_out);
                check_eq("final_err_last", err_last, exp_err_last);
                check_eq("in_q_empty", in_q.size(), 0);
                check_eq("exp_q_empty", exp_q.size(), 0);
                fin = 1;
            end

            @(posedge clock); #1;
            abort = 1'b0;
            cyc++;
            if (aborting) begin
                idle_inputs();
                @(negedge clock);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_done", done, 0);
                check_eq("abort_in_cnt", in_cnt, 0);
                check_eq("abort_out_cnt", out_cnt, 0);
                @(posedge clock); #1;
                @(negedge clock);
                check_eq("abort_no_done", done, 0);
                check_eq("abort_idle_busy", busy, 0);
                fin = 1;
            end
        end

        check_eq("frame_finished", fin, 1);
        if (fin && !aborting) begin
            idle_inputs();
            @(negedge clock);
            check_eq("done_once", done, 0);
            check_eq("idle_busy", busy, 0);
            check_eq("hold_in_cnt", in_cnt, len_in);
            check_eq("hold_out_cnt", out_cnt, len_out);
        end
        idle_inputs();
    endtask

    task automatic cfg_err_case(input int li, input int lo);
        @(posedge clock); #1;
        cfg_in_len  = CNT_W'(li);
        cfg_out_len = CNT_W'(lo);
        cfg_timeout = '0;
        start       = 1'b1;
        s_in_valid  = 1'b1;
        dp_in_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        check_eq("err_cfg_pulse", err_cfg, 1);
        check_eq("err_cfg_busy", busy, 0);
        check_eq("err_cfg_s_in_ready", s_in_ready, 0);
        @(posedge clock); #1;
        @(negedge clock);
        check_eq("err_cfg_clear", err_cfg, 0);
        check_eq("err_cfg_still_idle", busy, 0);
        idle_inputs();
    endtask

    task automatic timeout_case();
        int hs = 0;
        int n = 0;
        int guard = 0;
        @(posedge clock); #1;
        cfg_in_len  = 16;
        cfg_out_len = 4;
        cfg_timeout = 100;
        start       = 1'b1;
        @(posedge clock); #1;
        start       = 1'b0;
        s_in_valid  = 1'b1;
        dp_in_ready = 1'b1;
        while (hs < 5 && guard < 50) begin
            s_in_data = IN_W'($urandom);
            @(negedge clock);
            if (dp_in_valid && dp_in_ready) hs++;
            @(posedge clock); #1;
            guard++;
        end
        check_eq("to_five_samples", hs, 5);
        s_in_valid = 1'b0;
        // ERR is visible as dp_out_ready while the downstream sink is not ready.
        while (n < 300) begin
            @(negedge clock);
            if (dp_out_ready) break;
            @(posedge clock);
            n++;
        end
        check_eq("to_cycles", n, 100);
        check_eq("to_err_timeout", err_timeout, 1);
        #1;
        drive_all_active();
        @(negedge clock);
        check_eq("to_err_s_in_ready", s_in_ready, 0);
        check_eq("to_err_dp_in_valid", dp_in_valid, 0);
        check_eq("to_err_m_out_valid", m_out_valid, 0);
        check_eq("to_err_dp_out_ready", dp_out_ready, 1);
        check_eq("to_err_busy", busy, 0);
        repeat (5) @(posedge clock);
        @(negedge clock);
        check_eq("to_err_sticky", err_timeout, 1);
        @(posedge clock); #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        @(negedge clock);
        check_eq("to_abort_err_timeout", err_timeout, 0);
        check_eq("to_abort_s_in_ready", s_in_ready, 0);
        check_eq("to_abort_dp_out_ready", dp_out_ready, 0);
        check_eq("to_abort_in_cnt", in_cnt, 0);
        idle_inputs();
    endtask

    task automatic reset_mid_load_case();
        @(posedge clock); #1;
        cfg_in_len  = 100;
        cfg_out_len = 50;
        cfg_timeout = '0;
        start       = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        drive_all_active();
        dp_out_last = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        check_eq("rst_mid_busy_before", busy, 1);
        @(posedge clock); #1;
        RSTB = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_outputs_zero("rst_mid");
        @(posedge clock); #1;
        RSTB = 1'b0;
        @(negedge clock);
        check_outputs_zero("rst_mid_after");
        idle_inputs();
    endtask

    initial begin
        RSTB        = 1'b1;
        cfg_in_len  = '0;
        cfg_out_len = '0;
        cfg_timeout = '0;
        idle_inputs();
        drive_all_active();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_outputs_zero("reset");
        @(posedge clock); #1;
        RSTB = 1'b0;
        idle_inputs();

        run_frame(2048, 1536, 100, 100, 0, -1, 0);
        run_frame(2048, 1536, 50, 100, 0, -1, 0);
        run_frame(300, 200, 50, 60, 0, -1, 0);
        for (int i = 0; i < 6; i++) begin
            run_frame($urandom_range(1, 40), $urandom_range(1, 40),
                      $urandom_range(30, 100), $urandom_range(30, 100), 0, -1, 0);
        end
        run_frame(1, 1, 100, 100, 0, -1, 0);
        run_frame(8, 4, 100, 100, 1, -1, 0);
        run_frame(4, 4, 100, 100, 0, 1, 0);
        run_frame(6, 6, 100, 100, 0, -1, 0);
        cfg_err_case(5, 0);
        cfg_err_case(0, 7);
        run_frame(8, 4, 100, 100, 1, -1, 1);
        timeout_case();
        run_frame(10, 10, 70, 70, 0, -1, 0);
        reset_mid_load_case();
        run_frame(12, 5, 60, 80, 0, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
